// File: rtl/mod_range_counter.sv
// Registered up/down counter over the inclusive range [LOW, HIGH] with wrap-around,
// synchronous load, cascade carry/borrow-out and a registered two-digit BCD view of the count.
module mod_range_counter #(
    parameter int WIDTH   = 4,
    parameter int LOW     = 0,
    parameter int HIGH    = 11,
    parameter int RST_VAL = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             CI,
    input  logic             UP,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             CO,
    output logic [3:0]       TENS,
    output logic [3:0]       ONES,
    output logic             ERR
);

    if (!(LOW >= 0 && LOW < HIGH && HIGH < (2 ** WIDTH) && HIGH <= 99 &&
          RST_VAL >= LOW && RST_VAL <= HIGH)) begin : gen_param_check
        $error("mod_range_counter: illegal LOW/HIGH/RST_VAL for WIDTH");
    end

    localparam logic [WIDTH-1:0] LOW_W    = WIDTH'(LOW);
    localparam logic [WIDTH-1:0] HIGH_W   = WIDTH'(HIGH);
    localparam logic [WIDTH-1:0] RST_W    = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    localparam logic [3:0]       RST_TENS = 4'(RST_VAL / 10);
    localparam logic [3:0]       RST_ONES = 4'(RST_VAL % 10);

    logic [WIDTH-1:0] q_q, q_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;
    logic             err_q, err_d;
    logic             step;
    logic             at_high;
    logic             at_low;
    logic             ld_in_range;
    logic [6:0]       q_bcd;

    assign at_high     = (q_q == HIGH_W);
    assign at_low      = (q_q == LOW_W);
    assign step        = ~LD & ~EN & CI;
    // Range check in signed int so a zero LOW does not become a constant compare.
    assign ld_in_range = (int'(D) >= LOW) && (int'(D) <= HIGH);

    always_comb begin
        q_d   = q_q;
        err_d = err_q;
        if (LD) begin
            q_d   = ld_in_range ? D : LOW_W;
            err_d = ~ld_in_range;
        end else if (step) begin
            if (UP) begin
                q_d = at_high ? LOW_W : q_q + ONE_W;
            end else begin
                q_d = at_low ? HIGH_W : q_q - ONE_W;
            end
        end
        // BCD is derived from the next count so it lands on the same edge as Q.
        q_bcd  = 7'(q_d);
        tens_d = 4'(q_bcd / 7'd10);
        ones_d = 4'(q_bcd % 7'd10);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            q_q    <= RST_W;
            tens_q <= RST_TENS;
            ones_q <= RST_ONES;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            tens_q <= tens_d;
            ones_q <= ones_d;
            err_q  <= err_d;
        end
    end

    // Not gated by RST: chained stages must share the same reset.
    assign CO   = step & ((UP & at_high) | (~UP & at_low));
    assign Q    = q_q;
    assign TENS = tens_q;
    assign ONES = ones_q;
    assign ERR  = err_q;

endmodule

// File: tb/tb_mod_range_counter.sv
// Self-checking bench for mod_range_counter: vector table, directed corner sequences,
// a two-stage seconds cascade and randomized stimulus against an arithmetic model.
module tb_mod_range_counter;

    logic clk;
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default 0..11
    logic       a_rst, a_en, a_ci, a_up, a_ld, a_co, a_err;
    logic [3:0] a_d, a_q, a_tens, a_ones;
    // DUT B: 1..12, resets to 12
    logic       b_rst, b_en, b_ci, b_up, b_ld, b_co, b_err;
    logic [3:0] b_d, b_q, b_tens, b_ones;
    // Cascade: seconds ones 0..9 feeding tens 0..5
    logic       c_rst, c_en, c_up, c_ld, lo_co, hi_co, lo_err, hi_err;
    logic [3:0] c_d, lo_q, lo_tens, lo_ones, hi_q, hi_tens, hi_ones;

    mod_range_counter u_a (
        .CLK(clk), .RST(a_rst), .EN(a_en), .CI(a_ci), .UP(a_up), .LD(a_ld), .D(a_d),
        .Q(a_q), .CO(a_co), .TENS(a_tens), .ONES(a_ones), .ERR(a_err)
    );

    mod_range_counter #(.WIDTH(4), .LOW(1), .HIGH(12), .RST_VAL(12)) u_b (
        .CLK(clk), .RST(b_rst), .EN(b_en), .CI(b_ci), .UP(b_up), .LD(b_ld), .D(b_d),
        .Q(b_q), .CO(b_co), .TENS(b_tens), .ONES(b_ones), .ERR(b_err)
    );

    mod_range_counter #(.WIDTH(4), .LOW(0), .HIGH(9), .RST_VAL(0)) u_lo (
        .CLK(clk), .RST(c_rst), .EN(c_en), .CI(1'b1), .UP(c_up), .LD(c_ld), .D(c_d),
        .Q(lo_q), .CO(lo_co), .TENS(lo_tens), .ONES(lo_ones), .ERR(lo_err)
    );

    mod_range_counter #(.WIDTH(4), .LOW(0), .HIGH(5), .RST_VAL(0)) u_hi (
        .CLK(clk), .RST(c_rst), .EN(c_en), .CI(lo_co), .UP(c_up), .LD(c_ld), .D(c_d),
        .Q(hi_q), .CO(hi_co), .TENS(hi_tens), .ONES(hi_ones), .ERR(hi_err)
    );

    typedef struct {
        logic       rst, en, ci, up, ld;
        logic [3:0] d;
        int         q, err, co;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Q, BCD digits and ERR of DUT A against an expected count value.
    task automatic check_a(input string tag, input int q, input int err);
        check({tag, "_q"}, int'(a_q), q);
        check({tag, "_tens"}, int'(a_tens), q / 10);
        check({tag, "_ones"}, int'(a_ones), q % 10);
        check({tag, "_err"}, int'(a_err), err);
    endtask

    task automatic add(input logic rst, input logic en, input logic ci, input logic up,
                       input logic ld, input int d, input int q, input int err, input int co);
        vec_t v;
        v.rst = rst; v.en = en; v.ci = ci; v.up = up; v.ld = ld; v.d = 4'(d);
        v.q = q; v.err = err; v.co = co;
        vecs.push_back(v);
    endtask

    task automatic drive_a(input logic rst, input logic en, input logic ci, input logic up,
                           input logic ld, input logic [3:0] d);
        a_rst = rst; a_en = en; a_ci = ci; a_up = up; a_ld = ld; a_d = d;
    endtask

    // Next value within [lo, hi] using modular arithmetic on the range offset.
    function automatic int range_step(input int q, input int lo, input int hi, input bit up);
        int n;
        n = hi - lo + 1;
        return up ? lo + ((q - lo + 1) % n) : lo + ((q - lo - 1 + n) % n);
    endfunction

    initial begin
        int cur;
        int m_q, m_err, nxt, exp_co;
        bit stp;

        drive_a(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        b_rst = 1'b1; b_en = 1'b1; b_ci = 1'b1; b_up = 1'b0; b_ld = 1'b0; b_d = 4'd0;
        c_rst = 1'b1; c_en = 1'b1; c_up = 1'b1; c_ld = 1'b0; c_d = 4'd0;

        // rst en ci up ld d -> q err co(before edge)
        add(1, 0, 1, 1, 1,  5,  0, 0, 0);  // reset beats load
        add(0, 1, 0, 1, 1,  7,  7, 0, 0);  // load ignores EN
        add(0, 1, 1, 1, 1, 13,  0, 1, 0);  // out of range
        for (int i = 1; i <= 5; i++) add(0, 0, 1, 1, 0, 0, i, 1, 0);
        add(0, 1, 1, 1, 1,  3,  3, 0, 0);
        add(0, 1, 1, 1, 1, 11, 11, 0, 0);
        add(0, 0, 1, 1, 1,  4,  4, 0, 0);  // load wins over wrap, CO low
        add(0, 1, 1, 1, 1, 11, 11, 0, 0);
        add(0, 0, 1, 0, 0,  0, 10, 0, 0);  // turn around at HIGH
        add(0, 1, 1, 1, 1,  0,  0, 0, 0);
        add(0, 0, 1, 0, 0,  0, 11, 0, 1);  // borrow wrap
        add(0, 0, 1, 1, 0,  0,  0, 0, 1);  // carry wrap
        add(0, 1, 1, 1, 1, 15,  0, 1, 0);
        add(0, 1, 1, 1, 1, 12,  0, 1, 0);
        for (int i = 1; i <= 6; i++) add(0, 0, 1, 1, 0, 0, i, 1, 0);
        add(1, 0, 1, 1, 0,  0,  0, 0, 0);  // reset mid-count at 6

        foreach (vecs[i]) begin
            drive_a(vecs[i].rst, vecs[i].en, vecs[i].ci, vecs[i].up, vecs[i].ld, vecs[i].d);
            #1;
            check($sformatf("vec%0d_co", i), int'(a_co), vecs[i].co);
            tick();
            check_a($sformatf("vec%0d", i), vecs[i].q, vecs[i].err);
        end

        // 13 up-counts from reset
        drive_a(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        tick();
        check_a("up_rst", 0, 0);
        a_rst = 1'b0;
        cur = 0;
        for (int i = 0; i < 13; i++) begin
            #1;
            check($sformatf("up%0d_co", i), int'(a_co), (cur == 11) ? 1 : 0);
            tick();
            cur = (cur + 1) % 12;
            check_a($sformatf("up%0d", i), cur, 0);
        end

        // Hold at 5 with EN high, then with CI low
        drive_a(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
        tick();
        check_a("hold_ld", 5, 0);
        a_ld = 1'b0;
        for (int i = 0; i < 20; i++) begin
            a_en = (i < 10);
            a_ci = (i < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
            a_up = 1'($urandom_range(0, 1));
            #1;
            check($sformatf("hold%0d_co", i), int'(a_co), 0);
            tick();
            check_a($sformatf("hold%0d", i), 5, 0);
        end

        // DUT B: count down from 12
        b_rst = 1'b1;
        tick();
        check("b_rst_q", int'(b_q), 12);
        check("b_rst_tens", int'(b_tens), 1);
        check("b_rst_ones", int'(b_ones), 2);
        b_rst = 1'b0; b_en = 1'b0; b_ci = 1'b1; b_up = 1'b0;
        cur = 12;
        for (int i = 0; i < 12; i++) begin
            #1;
            check($sformatf("dn%0d_co", i), int'(b_co), (cur == 1) ? 1 : 0);
            tick();
            cur = (cur == 1) ? 12 : cur - 1;
            check($sformatf("dn%0d_q", i), int'(b_q), cur);
            check($sformatf("dn%0d_bcd", i), int'(b_tens) * 10 + int'(b_ones), cur);
        end
        b_en = 1'b1;

        // Seconds cascade
        c_rst = 1'b1;
        tick();
        check("sec_rst", int'(hi_q) * 10 + int'(lo_q), 0);
        c_rst = 1'b0; c_en = 1'b0;
        cur = 0;
        for (int i = 0; i < 60; i++) begin
            #1;
            check($sformatf("sec%0d_carry", i), int'(lo_co), (cur % 10 == 9) ? 1 : 0);
            tick();
            cur = (cur + 1) % 60;
            check($sformatf("sec%0d", i), int'(hi_q) * 10 + int'(lo_q), cur);
        end
        check("sec_err", int'(lo_err) + int'(hi_err), 0);
        check("sec_hi_co", int'(hi_co), 0);
        check("sec_bcd", int'(hi_ones) * 10 + int'(lo_ones) + int'(lo_tens) + int'(hi_tens), 0);

        // Randomized stimulus on DUT A against the range model
        m_q = 0; m_err = 0;
        for (int i = 0; i < 400; i++) begin
            drive_a((i == 0) || ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
            stp = !a_ld && !a_en && a_ci;
            nxt = range_step(m_q, 0, 11, a_up);
            exp_co = (stp && (a_up ? (nxt < m_q) : (nxt > m_q))) ? 1 : 0;
            #1;
            if (i > 0) check($sformatf("rnd%0d_co", i), int'(a_co), exp_co);
            if (a_rst) begin
                m_q = 0; m_err = 0;
            end else if (a_ld) begin
                m_err = (int'(a_d) > 11) ? 1 : 0;
                m_q = m_err ? 0 : int'(a_d);
            end else if (stp) begin
                m_q = nxt;
            end
            tick();
            check_a($sformatf("rnd%0d", i), m_q, m_err);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mod_range_counter.md
Name: mod_range_counter

Overview:
- Parametrised, registered successor to the team's 4-bit mod-12 next-state incrementer.
- Counts within an inclusive range [LOW, HIGH], up or down, with wrap-around.
- Supports synchronous load, cascade carry/borrow for chaining, and a registered two-digit BCD view for seven-segment display paths.
- Typical uses: seconds/minutes (0..59), 24-hour (0..23) and 12-hour (1..12) clock digits.

Parameters:
- WIDTH, 4: bit width of the count value Q and the load data D.
- LOW, 0: minimum count value (inclusive); reset target when RST_VAL = LOW.
- HIGH, 11: maximum count value (inclusive). Constraints: LOW < HIGH, HIGH < 2^WIDTH, HIGH <= 99. Elaboration fails otherwise.
- RST_VAL, 0: value Q takes on reset. Must satisfy LOW <= RST_VAL <= HIGH.

Ports:
- CLK, input, 1: clock; all state updates on the rising edge.
- RST, input, 1: synchronous reset, active-high.
- EN, input, 1: count enable, active-low (0 = counting allowed).
- CI, input, 1: cascade carry-in, active-high. Tie to 1 for the least-significant stage.
- UP, input, 1: direction; 1 = increment, 0 = decrement.
- LD, input, 1: synchronous load strobe, active-high.
- D, input, WIDTH: load value.
- Q, output, WIDTH: registered count.
- CO, output, 1: combinational carry/borrow-out; drives the next stage's CI.
- TENS, output, 4: registered BCD tens digit of Q.
- ONES, output, 4: registered BCD ones digit of Q.
- ERR, output, 1: registered sticky flag set by an out-of-range load.

Behaviour:
- Reset (RST = 1 at a clock edge): Q = RST_VAL; TENS/ONES = BCD of RST_VAL; ERR = 0. RST overrides all other inputs.
- Priority per edge: RST > LD > count > hold.
- Load (LD = 1): takes effect regardless of EN, CI and UP.
  - If LOW <= D <= HIGH: Q <= D; ERR <= 0.
  - Otherwise: Q <= LOW; ERR <= 1.
- Count step: occurs when LD = 0, EN = 0 and CI = 1.
  - UP = 1: Q <= (Q == HIGH) ? LOW : Q + 1.
  - UP = 0: Q <= (Q == LOW) ? HIGH : Q - 1.
  - ERR holds its value during counting.
- Hold: if no reset, load or count step applies, Q, TENS, ONES and ERR keep their values.
- Latency: one cycle from a qualifying edge to the updated Q.
- BCD outputs: TENS/ONES are computed from the next value of Q and registered on the same edge. They are therefore always coherent with Q, with no extra cycle of lag.
- CO = (~EN) & CI & (~LD) & ((UP & Q == HIGH) | (~UP & Q == LOW)).
  - Purely combinational; high exactly in the cycle before a wrap.
  - Forced low during LD. It is not gated by RST, so downstream stages must share the same RST.
- Arithmetic: all compares and increments are done at WIDTH bits. Q never leaves [LOW, HIGH] after reset.
- Reset mid-count: reset takes effect on the edge, discarding any pending step or load.
- Simultaneous LD and wrap condition: the load wins and CO is 0.
- Direction change at a boundary: for example Q = HIGH with UP switching to 0 gives Q <= HIGH - 1, no wrap and CO = 0.

Test Plan:
- Default params (0..11), RST = 1 for one cycle then EN = 0, CI = 1, UP = 1 for 13 cycles. Required: Q steps 0,1,…,11,0,1; CO = 1 only while Q = 11; TENS/ONES = 1/1 when Q = 11.
- LOW = 1, HIGH = 12, RST_VAL = 12, UP = 0 from reset. Required: Q steps 12,11,…,1,12; CO = 1 only while Q = 1; TENS/ONES = 1/2 at 12.
- Load D = 7 while EN = 1. Required: Q = 7 and ERR = 0 next cycle. Then load D = 13 (0..11 config). Required: Q = 0 and ERR = 1; ERR stays 1 through 5 count cycles; a later load of D = 3 clears ERR.
- Cascade two instances, 0..9 and 0..5, seconds style, with the low stage's CO driving the high stage's CI; run 60 cycles. Required: combined reading goes 00 → 59 → 00; the high stage advances only on cycles where the low stage is at 9.
- Q = 11 with EN = 0, CI = 1 and LD = 1, D = 4 in the same cycle. Required: CO = 0 and next Q = 4. Separately, assert RST mid-sequence at Q = 6. Required: next Q = RST_VAL and ERR = 0.
- EN = 1, or CI = 0, held for 10 cycles at Q = 5. Required: Q, TENS/ONES and ERR unchanged; CO = 0 throughout.
